// File: rtl/gate_test_sequencer_if.sv
// Bundle between the sweep sequencer and the gate-under-test harness.
// The slave side is the sequencer; the master side drives start/tables.
interface gate_test_sequencer_if #(
   parameter int ERR_W = 3
);
   logic             start;
   logic [3:0]       truth_tbl;
   logic             gate_y;
   logic             gate_a;
   logic             gate_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [3:0]       fail_vec;

   modport master (
      output start, truth_tbl, gate_y,
      input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
   );

   modport slave (
      input  start, truth_tbl, gate_y,
      output gate_a, gate_b, busy, done, pass, err_count, fail_vec
   );
endinterface

// File: rtl/gate_test_sequencer.sv
// Drives all four operand pairs into an external 2-input gate and checks
// gate_y against a latched truth table, reporting per-vector failures.
module gate_test_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 3
) (
   input logic clk,
   input logic rst_n,
   gate_test_sequencer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] W_LAST =
      CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic [3:0]       tbl_q, tbl_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [3:0]       fail_q, fail_d;
   logic             pass_q, pass_d;
   logic             busy;
   logic             accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         wcnt_q  <= '0;
         tbl_q   <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         tbl_q   <= tbl_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      tbl_d   = tbl_q;
      err_d   = err_q;
      fail_d  = fail_q;
      pass_d  = pass_q;
      // The edge leaving DONE is the first IDLE-equivalent edge, so a held
      // start chains sweeps without an idle bubble.
      accept  = bus.start && (state_q == IDLE || state_q == DONE);
      unique case (state_q)
         IDLE: state_d = IDLE;
         DRIVE: begin
            wcnt_d  = '0;
            state_d = (SETTLE_CYCLES > 0) ? WAIT : CHECK;
         end
         WAIT: begin
            if (wcnt_q == W_LAST) state_d = CHECK;
            else wcnt_d = wcnt_q + 1'b1;
         end
         CHECK: begin
            if (bus.gate_y != tbl_q[idx_q]) begin
               fail_d[idx_q] = 1'b1;
               if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            end
            if (idx_q == 2'd3) begin
               state_d = DONE;
               pass_d  = (fail_d == 4'b0000);
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = DRIVE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (accept) begin
         tbl_d   = bus.truth_tbl;
         idx_d   = '0;
         err_d   = '0;
         fail_d  = '0;
         state_d = DRIVE;
      end
   end

   assign busy          = (state_q == DRIVE) || (state_q == WAIT) ||
                          (state_q == CHECK);
   assign bus.busy      = busy;
   assign bus.done      = (state_q == DONE);
   assign bus.gate_a    = busy & idx_q[1];
   assign bus.gate_b    = busy & idx_q[0];
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_vec  = fail_q;
endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench: three sequencer configurations against gate models;
// stimulus pushes expected sweep results, a negedge monitor checks them.
module tb_gate_test_sequencer;
   typedef struct {
      int         cyc;
      int         lat;
      logic [2:0] err;
      logic [3:0] fv;
      logic       ps;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   logic       st[3];
   logic [3:0] tb[3];
   logic       m0;

   gate_test_sequencer_if #(.ERR_W(3)) if0 ();
   gate_test_sequencer_if #(.ERR_W(2)) if1 ();
   gate_test_sequencer_if #(.ERR_W(3)) if2 ();

   gate_test_sequencer #(.SETTLE_CYCLES(1), .ERR_W(3)) u0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave));
   gate_test_sequencer #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));
   gate_test_sequencer #(.SETTLE_CYCLES(0), .ERR_W(3)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(if2.slave));

   assign if0.start     = st[0];
   assign if1.start     = st[1];
   assign if2.start     = st[2];
   assign if0.truth_tbl = tb[0];
   assign if1.truth_tbl = tb[1];
   assign if2.truth_tbl = tb[2];
   // u0: AND gate or stuck-at-1; u1: inverted AND; u2: OR gate
   assign if0.gate_y = m0 ? 1'b1 : (if0.gate_a & if0.gate_b);
   assign if1.gate_y = ~(if1.gate_a & if1.gate_b);
   assign if2.gate_y = if2.gate_a | if2.gate_b;

   logic       dn[3], bz[3], ps[3];
   logic [1:0] av[3];
   logic [2:0] er[3];
   logic [3:0] fv[3];
   assign dn[0] = if0.done;  assign dn[1] = if1.done;  assign dn[2] = if2.done;
   assign bz[0] = if0.busy;  assign bz[1] = if1.busy;  assign bz[2] = if2.busy;
   assign ps[0] = if0.pass;  assign ps[1] = if1.pass;  assign ps[2] = if2.pass;
   assign av[0] = {if0.gate_a, if0.gate_b};
   assign av[1] = {if1.gate_a, if1.gate_b};
   assign av[2] = {if2.gate_a, if2.gate_b};
   assign er[0] = if0.err_count;
   assign er[1] = {1'b0, if1.err_count};
   assign er[2] = if2.err_count;
   assign fv[0] = if0.fail_vec; assign fv[1] = if1.fail_vec;
   assign fv[2] = if2.fail_vec;

   exp_t q0[$], q1[$], q2[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, want, cyc);
      end
   endtask

   // Monitor: track operand order and busy length, check on each done.
   logic [7:0] seq[3];
   int         nb[3];
   logic [1:0] lastv[3];
   bit         bzp[3];
   exp_t       me;
   bit         got;
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (bz[k]) begin
            if (!bzp[k]) begin
               seq[k] = {6'b111111, av[k]};
               nb[k]  = 1;
            end else begin
               nb[k]++;
               if (av[k] != lastv[k]) seq[k] = {seq[k][5:0], av[k]};
            end
            lastv[k] = av[k];
         end
         if (dn[k]) begin
            got = 1'b0;
            case (k)
               0: if (q0.size() > 0) begin me = q0.pop_front(); got = 1'b1; end
               1: if (q1.size() > 0) begin me = q1.pop_front(); got = 1'b1; end
               default:
                  if (q2.size() > 0) begin me = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
               chk($sformatf("u%0d unexpected_done", k), 32'd1, 32'd0);
            end else begin
               chk($sformatf("u%0d done_cycle", k), cyc, me.cyc);
               chk($sformatf("u%0d err_count", k), {29'd0, er[k]},
                   {29'd0, me.err});
               chk($sformatf("u%0d fail_vec", k), {28'd0, fv[k]},
                   {28'd0, me.fv});
               chk($sformatf("u%0d pass", k), {31'd0, ps[k]},
                   {31'd0, me.ps});
               chk($sformatf("u%0d vec_order", k), {24'd0, seq[k]},
                   32'h1B);
               chk($sformatf("u%0d busy_cycles", k), nb[k], me.lat);
               chk($sformatf("u%0d ab_in_done", k), {30'd0, av[k]}, 32'd0);
            end
         end
         bzp[k] = bz[k];
      end
   end

   task automatic sweep(input int k, input logic [2:0] e,
                        input logic [3:0] f, input logic p,
                        input bit push, output int acc);
      exp_t x;
      int lat;
      lat   = (k == 2) ? 8 : 12;
      acc   = cyc + 1;
      x.cyc = acc + lat;
      x.lat = lat;
      x.err = e;
      x.fv  = f;
      x.ps  = p;
      if (push) begin
         case (k)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
         endcase
      end
      st[k] = 1'b1;
      @(negedge clk);
      st[k] = 1'b0;
   endtask

   task automatic hold(input int k, input logic [2:0] e,
                       input logic [3:0] f, input logic p);
      chk($sformatf("u%0d hold_err", k), {29'd0, er[k]}, {29'd0, e});
      chk($sformatf("u%0d hold_fail", k), {28'd0, fv[k]}, {28'd0, f});
      chk($sformatf("u%0d hold_pass", k), {31'd0, ps[k]}, {31'd0, p});
      chk($sformatf("u%0d hold_busy", k), {31'd0, bz[k]}, 32'd0);
   endtask

   task automatic reset_state(input int k, input string tag);
      chk({tag, " busy"}, {31'd0, bz[k]}, 32'd0);
      chk({tag, " done"}, {31'd0, dn[k]}, 32'd0);
      chk({tag, " pass"}, {31'd0, ps[k]}, 32'd0);
      chk({tag, " err"}, {29'd0, er[k]}, 32'd0);
      chk({tag, " fail"}, {28'd0, fv[k]}, 32'd0);
      chk({tag, " ab"}, {30'd0, av[k]}, 32'd0);
   endtask

   initial begin
      int acc;
      exp_t x;
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b0;
         tb[k] = 4'b1000;
      end
      m0    = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) reset_state(k, $sformatf("u%0d reset", k));
      rst_n = 1'b1;
      @(negedge clk);

      // Correct AND gate, stray start pulse while busy
      sweep(0, 3'd0, 4'b0000, 1'b1, 1'b1, acc);
      repeat (4) @(negedge clk);
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (10) @(negedge clk);
      hold(0, 3'd0, 4'b0000, 1'b1);

      // Stuck-at-1 output
      m0 = 1'b1;
      sweep(0, 3'd3, 4'b0111, 1'b0, 1'b1, acc);
      repeat (15) @(negedge clk);
      hold(0, 3'd3, 4'b0111, 1'b0);
      m0 = 1'b0;

      // Held start: three chained sweeps, done every 13 cycles
      acc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
         x.cyc = acc + 12 + 13 * i;
         x.lat = 12;
         x.err = 3'd0;
         x.fv  = 4'b0000;
         x.ps  = 1'b1;
         q0.push_back(x);
      end
      st[0] = 1'b1;
      repeat (27) @(negedge clk);
      st[0] = 1'b0;
      repeat (18) @(negedge clk);
      hold(0, 3'd0, 4'b0000, 1'b1);

      // Reset during WAIT of vector 2, with start asserted alongside
      m0 = 1'b1;
      sweep(0, 3'd0, 4'b0000, 1'b0, 1'b0, acc);
      repeat (7) @(negedge clk);
      chk("u0 mid_err", {29'd0, er[0]}, 32'd2);
      chk("u0 mid_fail", {28'd0, fv[0]}, 32'h3);
      chk("u0 mid_ab", {30'd0, av[0]}, 32'd2);
      st[0] = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      reset_state(0, "u0 abort");
      rst_n = 1'b1;
      st[0] = 1'b0;
      m0    = 1'b0;
      repeat (16) @(negedge clk);
      chk("u0 no_done_after_abort", {31'd0, dn[0]}, 32'd0);
      sweep(0, 3'd0, 4'b0000, 1'b1, 1'b1, acc);
      repeat (15) @(negedge clk);

      // Narrow counter saturates; every vector fails
      sweep(1, 3'd3, 4'b1111, 1'b0, 1'b1, acc);
      repeat (15) @(negedge clk);
      hold(1, 3'd3, 4'b1111, 1'b0);

      // No settle wait, OR gate, table changed mid-sweep
      tb[2] = 4'b1110;
      sweep(2, 3'd0, 4'b0000, 1'b1, 1'b1, acc);
      tb[2] = 4'b0001;
      repeat (3) @(negedge clk);
      tb[2] = 4'b0110;
      repeat (10) @(negedge clk);
      hold(2, 3'd0, 4'b0000, 1'b1);

      repeat (5) @(negedge clk);
      chk("u0 pending_done", q0.size(), 32'd0);
      chk("u1 pending_done", q1.size(), 32'd0);
      chk("u2 pending_done", q2.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gate_test_sequencer.md
GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001: The module SHALL have parameter SETTLE_CYCLES, default 1, which sets the number of wait cycles between driving a vector and sampling gate_y (0 = no wait state).
REQ-002: The module SHALL have parameter ERR_W, default 3, which sets the width of the error counter.
REQ-003: clk  input  1  sole clock; all state changes on its rising edge.
REQ-004: rst_n  input  1  reset; synchronous, active-low.
REQ-005: start  input  1  request to run one full truth-table sweep.
REQ-006: truth_tbl  input  4  expected gate output; bit i is the expected gate_y when {gate_a,gate_b}==i (AND gate = 4'b1000).
REQ-007: gate_y  input  1  output of the external 2-input gate under test.
REQ-008: gate_a, gate_b  output  1 each  operands driven to the gate under test.
REQ-009: busy  output  1  high while a sweep is in progress.
REQ-010: done  output  1  single-cycle pulse at sweep end.
REQ-011: pass  output  1  high when the last sweep had zero mismatches.
REQ-012: err_count  output  ERR_W  mismatches in the last or current sweep, saturating.
REQ-013: fail_vec  output  4  bit i set when vector i mismatched.

Function
REQ-014: The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-015: In IDLE with start=1 at an edge, the block SHALL latch truth_tbl, set vector index idx=0, clear err_count and fail_vec, and enter DRIVE.
REQ-016: While busy, {gate_a,gate_b} SHALL equal idx; in IDLE and DONE both SHALL be 0.
REQ-017: DRIVE SHALL last 1 cycle, then go to WAIT (SETTLE_CYCLES>0) or directly to CHECK (SETTLE_CYCLES=0).
REQ-018: WAIT SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-019: CHECK SHALL last 1 cycle and compare gate_y with latched truth_tbl[idx].
REQ-020: On a mismatch in CHECK, the block SHALL set fail_vec[idx] and increment err_count, saturating at 2^ERR_W-1 with no wrap.
REQ-021: After CHECK, if idx<3 the block SHALL increment idx and go to DRIVE; if idx==3 it SHALL go to DONE.
REQ-022: DONE SHALL last 1 cycle with done=1, update pass to (no mismatch in this sweep), then return to IDLE.
REQ-023: busy SHALL be 1 in DRIVE, WAIT and CHECK, and 0 in IDLE and DONE.
REQ-024: Latency: done SHALL be high in the cycle that begins 4*(SETTLE_CYCLES+2) edges after the edge that accepted start (12 for default).
REQ-025: start SHALL be ignored while busy or in DONE; a start held high SHALL begin a new sweep on the first edge back in IDLE.
REQ-026: Changes to truth_tbl during a sweep SHALL NOT affect that sweep.
REQ-027: err_count, fail_vec and pass SHALL hold their values in IDLE until the next accepted start.
REQ-028: pass SHALL remain 0 when saturation occurred, because pass is derived from any mismatch, not from the counter value.

Reset
REQ-029: With rst_n=0 at an edge, the block SHALL enter IDLE and set idx=0, gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_count=0 and fail_vec=0.
REQ-030: Reset asserted mid-sweep SHALL abort the sweep without a done pulse, and the sweep results SHALL be discarded.
REQ-031: Reset SHALL take priority over start in the same cycle.

Verification
REQ-032: Correct AND gate model, truth_tbl=4'b1000, start pulse -> vectors 00,01,10,11 driven in order; done 12 cycles after start; pass=1, err_count=0, fail_vec=0.
REQ-033: gate_y stuck at 1, truth_tbl=4'b1000 -> err_count=3, fail_vec=4'b0111, pass=0.
REQ-034: ERR_W=2, gate_y=~expected on all vectors -> err_count saturates at 3, fail_vec=4'b1111, pass=0.
REQ-035: start held high continuously -> back-to-back sweeps with done pulses 13 cycles apart (default SETTLE_CYCLES); start pulses during busy are ignored.
REQ-036: rst_n=0 during WAIT of vector 2 -> next cycle all outputs reset and no done pulse; a following start yields a full clean sweep.
REQ-037: SETTLE_CYCLES=0 with an OR gate model, truth_tbl=4'b1110 -> done 8 cycles after start, pass=1; truth_tbl toggled mid-sweep -> result unchanged.
